ibex_fetch_req_ctrl: RTL and testbench

Instruction-fetch request controller that sits directly upstream of the fetch FIFO. It issues word-aligned requests on the instruction bus (req/gnt/rvalid protocol) and tracks up to NUM_REQS outstanding transactions. It throttles on FIFO occupancy, discards stale responses after a branch, and pushes in-order responses with their error flag into the FIFO write port. On a branch it drives the FIFO clear together with the branch target.

---
 rtl/ibex_fetch_req_ctrl_pkg.sv | 13 +
 rtl/ibex_fetch_req_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ibex_fetch_req_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ibex_fetch_req_ctrl_pkg.sv
// Shared types and helpers for the instruction-fetch request controller.
package ibex_fetch_req_ctrl_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_GNT = 1'b1
   } fetch_req_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ibex_fetch_req_ctrl.sv
// Fetch request controller: issues word-aligned bus requests, tracks outstanding
// transactions, drops stale responses after a branch and feeds the fetch FIFO.
module ibex_fetch_req_ctrl
   import ibex_fetch_req_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQS = 2,
   parameter bit          ResetAll = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                branch_i,
   input  logic [31:0]         addr_i,
   input  logic [NUM_REQS-1:0] fifo_busy_i,
   output logic                fifo_clear_o,
   output logic                fifo_valid_o,
   output logic [31:0]         fifo_addr_o,
   output logic [31:0]         fifo_rdata_o,
   output logic                fifo_err_o,
   output logic                instr_req_o,
   input  logic                instr_gnt_i,
   output logic [31:0]         instr_addr_o,
   input  logic                instr_rvalid_i,
   input  logic [31:0]         instr_rdata_i,
   input  logic                instr_err_i,
   output logic                busy_o
);

   fetch_req_state_e    state_q, state_d;
   logic [NUM_REQS-1:0] out_q, out_d, disc_q, disc_d;
   logic [NUM_REQS-1:0] out_shift, disc_shift;
   logic [31:0]         fetch_addr_q, fetch_addr_d;
   logic [31:0]         stored_addr_q, stored_addr_d;
   logic [31:0]         branch_addr, req_addr;
   logic                disc_pend_q, disc_pend_d;
   logic [7:0]          out_cnt, busy_cnt, shift_cnt;
   logic                slot_free, fifo_room, new_req, gnt_acc, gnt_disc;

   assign branch_addr = word_align(addr_i);
   assign req_addr    = branch_i ? branch_addr : fetch_addr_q;

   // Occupancy of the tracker and of the FIFO upper entries
   always_comb begin
      out_cnt  = 8'd0;
      busy_cnt = 8'd0;
      for (int i = 0; i < NUM_REQS; i++) begin
         out_cnt  = out_cnt + {7'd0, out_q[i]};
         busy_cnt = busy_cnt + {7'd0, fifo_busy_i[i]};
      end
   end

   // A retiring response frees a slot in the same cycle; a branch clears the FIFO
   assign slot_free = ~out_q[NUM_REQS-1] | instr_rvalid_i;
   assign fifo_room = branch_i | ((out_cnt + busy_cnt) < 8'(NUM_REQS));
   assign new_req   = req_i & slot_free & fifo_room;
   assign gnt_acc   = instr_req_o & instr_gnt_i;

   // Request FSM: next state, bus request and fetch address
   always_comb begin
      state_d       = state_q;
      stored_addr_d = stored_addr_q;
      fetch_addr_d  = fetch_addr_q;
      disc_pend_d   = disc_pend_q;
      instr_req_o   = 1'b0;
      instr_addr_o  = fetch_addr_q;
      gnt_disc      = 1'b0;
      case (state_q)
         IDLE: begin
            instr_req_o  = new_req;
            instr_addr_o = req_addr;
            if (new_req && instr_gnt_i) begin
               fetch_addr_d = req_addr + 32'd4;
            end else begin
               fetch_addr_d = req_addr;
            end
            if (new_req && !instr_gnt_i) begin
               state_d       = WAIT_GNT;
               stored_addr_d = req_addr;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_GNT: begin
            // Bus rule: the pending request is held unchanged until granted
            instr_req_o  = 1'b1;
            instr_addr_o = stored_addr_q;
            gnt_disc     = disc_pend_q | branch_i;
            if (branch_i) begin
               fetch_addr_d = branch_addr;
            end else if (instr_gnt_i && !disc_pend_q) begin
               fetch_addr_d = fetch_addr_q + 32'd4;
            end else begin
               fetch_addr_d = fetch_addr_q;
            end
            if (instr_gnt_i) begin
               state_d     = IDLE;
               disc_pend_d = 1'b0;
            end else begin
               state_d     = WAIT_GNT;
               disc_pend_d = disc_pend_q | branch_i;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outstanding tracker: retire at bit 0, append granted request above the rest
   always_comb begin
      if (instr_rvalid_i) begin
         out_shift  = out_q >> 1;
         disc_shift = disc_q >> 1;
      end else begin
         out_shift  = out_q;
         disc_shift = disc_q;
      end
      shift_cnt = 8'd0;
      for (int i = 0; i < NUM_REQS; i++) begin
         shift_cnt = shift_cnt + {7'd0, out_shift[i]};
      end
      out_d = out_shift;
      if (branch_i) begin
         disc_d = disc_shift | out_shift;
      end else begin
         disc_d = disc_shift;
      end
      for (int i = 0; i < NUM_REQS; i++) begin
         if (gnt_acc && (shift_cnt == 8'(i))) begin
            out_d[i]  = 1'b1;
            disc_d[i] = gnt_disc;
         end else begin
            out_d[i]  = out_d[i];
            disc_d[i] = disc_d[i];
         end
      end
   end

   // Control state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         out_q       <= '0;
         disc_q      <= '0;
         disc_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         disc_q      <= disc_d;
         disc_pend_q <= disc_pend_d;
      end
   end

   generate
      if (ResetAll) begin : g_addr_rst
         // Address datapath with reset
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               fetch_addr_q  <= 32'd0;
               stored_addr_q <= 32'd0;
            end else begin
               fetch_addr_q  <= fetch_addr_d;
               stored_addr_q <= stored_addr_d;
            end
         end
      end else begin : g_addr_nrst
         // Address datapath without reset
         always_ff @(posedge clk_i) begin
            fetch_addr_q  <= fetch_addr_d;
            stored_addr_q <= stored_addr_d;
         end
      end
   endgenerate

   assign fifo_valid_o = instr_rvalid_i & ~disc_q[0] & ~branch_i;
   assign fifo_rdata_o = instr_rdata_i;
   assign fifo_err_o   = instr_err_i;
   assign fifo_clear_o = branch_i;
   assign fifo_addr_o  = addr_i;
   assign busy_o       = (|out_q) | (state_q == WAIT_GNT);

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Bench for ibex_fetch_req_ctrl: directed scenarios plus random traffic checked
// against a transaction-level model (queue of outstanding fetches).
module tb_ibex_fetch_req_ctrl;

   localparam int N = 2;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          req_i, branch_i;
   logic [31:0]   addr_i;
   logic [N-1:0]  fifo_busy_i;
   logic          fifo_clear_o, fifo_valid_o, fifo_err_o;
   logic [31:0]   fifo_addr_o, fifo_rdata_o;
   logic          instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i, busy_o;
   logic [31:0]   instr_addr_o, instr_rdata_i;

   ibex_fetch_req_ctrl #(.NUM_REQS(N), .ResetAll(1'b0)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i),
      .addr_i(addr_i), .fifo_busy_i(fifo_busy_i), .fifo_clear_o(fifo_clear_o),
      .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o),
      .fifo_rdata_o(fifo_rdata_o), .fifo_err_o(fifo_err_o),
      .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
      .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] addr;
      logic        disc;
   } txn_t;

   txn_t        m_q[$];
   logic        m_pend, m_pend_disc;
   logic [31:0] m_pend_addr, m_next;
   int          n_chk, n_pass;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, compare against the model mid-cycle, advance the model
   task automatic step(input logic r, input logic b, input logic [31:0] a,
                       input logic [N-1:0] busy, input logic g, input logic v,
                       input logic [31:0] rd, input logic e);
      logic        vv, exp_req, exp_fv, gnt_eff;
      logic [31:0] exp_addr, tgt;
      int          busy_n;
      txn_t        t;
      vv     = v && (m_q.size() > 0);
      tgt    = {a[31:2], 2'b00};
      busy_n = $countones(busy);
      req_i = r; branch_i = b; addr_i = a; fifo_busy_i = busy;
      instr_gnt_i = g; instr_rvalid_i = vv; instr_rdata_i = rd; instr_err_i = e;
      if (m_pend) begin
         exp_req  = 1'b1;
         exp_addr = m_pend_addr;
      end else begin
         exp_req  = r && (m_q.size() < N || vv) && (b || (m_q.size() + busy_n) < N);
         exp_addr = b ? tgt : m_next;
      end
      exp_fv = vv && !m_q[0].disc && !b;
      #3;
      check_eq("req", {31'd0, instr_req_o}, {31'd0, exp_req});
      if (exp_req) check_eq("addr", instr_addr_o, exp_addr);
      check_eq("fifo_valid", {31'd0, fifo_valid_o}, {31'd0, exp_fv});
      if (exp_fv) begin
         check_eq("rdata", fifo_rdata_o, rd);
         check_eq("err", {31'd0, fifo_err_o}, {31'd0, e});
      end
      check_eq("clear", {31'd0, fifo_clear_o}, {31'd0, b});
      if (b) check_eq("fifo_addr", fifo_addr_o, a);
      check_eq("busy", {31'd0, busy_o}, {31'd0, (m_pend || m_q.size() > 0)});
      @(posedge clk_i);
      gnt_eff = exp_req && g;
      if (vv) m_q.delete(0);
      if (b) foreach (m_q[i]) m_q[i].disc = 1'b1;
      if (m_pend) begin
         if (b) begin
            m_pend_disc = 1'b1;
            m_next      = tgt;
         end
         if (gnt_eff) begin
            t.addr = m_pend_addr; t.disc = m_pend_disc;
            m_q.push_back(t);
            if (!m_pend_disc) m_next = m_pend_addr + 32'd4;
            m_pend = 1'b0; m_pend_disc = 1'b0;
         end
      end else if (exp_req) begin
         if (gnt_eff) begin
            t.addr = exp_addr; t.disc = 1'b0;
            m_q.push_back(t);
            m_next = exp_addr + 32'd4;
         end else begin
            m_pend = 1'b1; m_pend_addr = exp_addr; m_pend_disc = 1'b0;
            m_next = exp_addr;
         end
      end else if (b) begin
         m_next = tgt;
      end
      #1;
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      m_pend = 1'b0; m_pend_disc = 1'b0; m_pend_addr = 32'd0; m_next = 32'd0;
      req_i = 1'b0; branch_i = 1'b0; addr_i = 32'd0; fifo_busy_i = '0;
      instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'd0; instr_err_i = 1'b0;
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check_eq("rst_req", {31'd0, instr_req_o}, 32'd0);
      check_eq("rst_valid", {31'd0, fifo_valid_o}, 32'd0);
      check_eq("rst_clear", {31'd0, fifo_clear_o}, 32'd0);
      check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
      rst_i = 1'b0;

      // Branch to 0x100, immediate grants, response next cycle
      step(1'b1, 1'b1, 32'h100, 2'b00, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
      step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h12345678, 1'b0);
      // FIFO full stall, then a single request once it drains
      repeat (3) step(1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h1111_0000, 1'b0);
      // Two outstanding then branch to an unaligned target
      step(1'b1, 1'b1, 32'h200, 2'b00, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b1, 32'h302, 2'b00, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'hAAAA_0200, 1'b0);
      step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'hAAAA_0204, 1'b0);
      step(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'hBBBB_0300, 1'b0);
      // Grant withheld while a branch arrives
      step(1'b1, 1'b1, 32'h500, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b1, 32'h400, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'hCCCC_0500, 1'b0);
      step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'hCCCC_0400, 1'b0);
      // Bus error is forwarded and fetching continues
      step(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'hE000_0404, 1'b1);
      step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'hE000_0408, 1'b0);
      // Asynchronous reset with one request outstanding
      step(1'b1, 1'b1, 32'h600, 2'b00, 1'b1, 1'b0, 32'd0, 1'b0);
      req_i = 1'b0; branch_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      check_eq("arst_req", {31'd0, instr_req_o}, 32'd0);
      check_eq("arst_valid", {31'd0, fifo_valid_o}, 32'd0);
      check_eq("arst_clear", {31'd0, fifo_clear_o}, 32'd0);
      check_eq("arst_busy", {31'd0, busy_o}, 32'd0);
      m_q.delete(); m_pend = 1'b0; m_pend_disc = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0);

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         logic [N-1:0] bz;
         bz = ($urandom_range(3) == 0) ? N'($urandom_range(3)) : '0;
         step(($urandom_range(7) != 0), (k == 0) || ($urandom_range(9) == 0), $urandom,
              bz, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom,
              ($urandom_range(7) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
